// File: rtl/float_result_collector.sv
// Rebuilds 32-bit IEEE-754 singles from hi/lo 16-bit divider words, classifies them and queues them in a FIFO.
// Optional build macro FLOAT_COLLECT_CANON_NAN_EN: store every NaN as the canonical quiet NaN 32'h7FC00000.
//
// state  | meaning
// GET_HI | waiting for hi word; ack offered only while FIFO has room
// GET_LO | waiting for lo word; FIFO slot already reserved
// WRITE  | pushing {class, hi, lo} into the FIFO
module float_result_collector #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       input_z,
    input  logic              input_z_stb,
    output logic              input_z_ack,
    output logic [31:0]       output_z,
    output logic [3:0]        output_z_class,
    output logic              output_z_stb,
    input  logic              output_z_ack,
    output logic [ADDR_W:0]   fill_level
);

    typedef enum logic [1:0] {
        GET_HI = 2'd0,
        GET_LO = 2'd1,
        WRITE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                ack_q, ack_d;
    logic [15:0]         hi_q, hi_d;
    logic [15:0]         lo_q, lo_d;
    logic [35:0]         mem_q [DEPTH];
    logic [35:0]         mem_d [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;

    logic [31:0]         z_full;
    logic [31:0]         z_store;
    logic [7:0]          z_exp;
    logic [22:0]         z_man;
    logic [3:0]          z_class;
    logic                full;
    logic                push;
    logic                pop;
    logic                xfer;

    always_comb begin
        z_full  = {hi_q, lo_q};
        z_exp   = z_full[30:23];
        z_man   = z_full[22:0];
        z_class = {(z_exp == 8'hFF) && (z_man != '0),
                   (z_exp == 8'hFF) && (z_man == '0),
                   (z_exp == 8'h00) && (z_man == '0),
                   (z_exp == 8'h00) && (z_man != '0)};
`ifdef FLOAT_COLLECT_CANON_NAN_EN
        z_store = z_class[3] ? 32'h7FC0_0000 : z_full;
`else
        z_store = z_full;
`endif
    end

    always_comb begin
        state_d  = state_q;
        ack_d    = ack_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        full = (count_q == (ADDR_W+1)'(DEPTH));
        xfer = input_z_stb && ack_q;
        push = (state_q == WRITE);
        pop  = (count_q != '0) && output_z_ack;

        case (state_q)
            GET_HI: begin
                if (xfer) begin
                    hi_d    = input_z;
                    ack_d   = 1'b0;
                    state_d = GET_LO;
                end else begin
                    ack_d = !full;
                end
            end
            GET_LO: begin
                if (xfer) begin
                    lo_d    = input_z;
                    ack_d   = 1'b0;
                    state_d = WRITE;
                end else begin
                    ack_d = 1'b1;
                end
            end
            WRITE: begin
                ack_d   = 1'b0;
                state_d = GET_HI;
            end
            default: begin
                ack_d   = 1'b0;
                state_d = GET_HI;
            end
        endcase

        // The slot was reserved when the hi word was accepted, so a push never overflows.
        if (push) begin
            mem_d[wr_ptr_q] = {z_class, z_store};
            wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        count_d = count_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= GET_HI;
            ack_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign input_z_ack    = ack_q;
    assign output_z       = mem_q[rd_ptr_q][31:0];
    assign output_z_class = mem_q[rd_ptr_q][35:32];
    assign output_z_stb   = (count_q != '0);
    assign fill_level     = count_q;

endmodule

// File: tb/tb_float_result_collector.sv
// Scoreboard bench for float_result_collector: driver pushes expected results, negedge monitor pops and compares.
module tb_float_result_collector;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [15:0]       input_z;
    logic              input_z_stb;
    logic              input_z_ack;
    logic [31:0]       output_z;
    logic [3:0]        output_z_class;
    logic              output_z_stb;
    logic              output_z_ack;
    logic [ADDR_W:0]   fill_level;

    typedef struct {
        logic [31:0] z;
        logic [3:0]  c;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pushes = 0;
    int   pops   = 0;
    int   stb_rises = 0;
    logic stb_prev = 1'b0;
    bit   rand_ack = 1'b0;

    float_result_collector #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .input_z        (input_z),
        .input_z_stb    (input_z_stb),
        .input_z_ack    (input_z_ack),
        .output_z       (output_z),
        .output_z_class (output_z_class),
        .output_z_stb   (output_z_stb),
        .output_z_ack   (output_z_ack),
        .fill_level     (fill_level)
    );

    always #5 clk = ~clk;

    // Reference: classification straight from exponent/mantissa arithmetic.
    function automatic exp_t model(input logic [31:0] raw);
        exp_t r;
        int unsigned e, m;
        e   = (int'(raw) >>> 23) & 255;
        m   = int'(raw) & 32'h007F_FFFF;
        r.z = raw;
        r.c = 4'd0;
        if (e == 255 && m != 0) begin
            r.c = 4'd8;
`ifdef FLOAT_COLLECT_CANON_NAN_EN
            r.z = 32'h7FC0_0000;
`endif
        end else if (e == 255) r.c = 4'd4;
        else if (e == 0 && m == 0) r.c = 4'd2;
        else if (e == 0) r.c = 4'd1;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic send_word(input logic [15:0] w, output bit ok);
        ok = 1'b0;
        input_z     = w;
        input_z_stb = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (input_z_ack) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
        input_z_stb = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: word %h never accepted", w);
        end
    endtask

    task automatic send_pair(input logic [31:0] raw);
        bit ok;
        send_word(raw[31:16], ok);
        if (ok) begin
            send_word(raw[15:0], ok);
            if (ok) begin
                sb_q.push_back(model(raw));
                pushes++;
            end
        end
    endtask

    task automatic wait_drain(input string name);
        int k;
        for (k = 0; k < 500; k++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !output_z_stb) break;
        end
        check({name, "_drained"}, 64'(sb_q.size()), 64'd0);
        check({name, "_fill"}, 64'(fill_level), 64'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (output_z_stb && !stb_prev) stb_rises++;
            stb_prev <= output_z_stb;
            if (output_z_stb && output_z_ack) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h with no result pending", output_z);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("out_data", 64'(output_z), 64'(e.z));
                    check("out_class", 64'(output_z_class), 64'(e.c));
                    pops++;
                end
            end
        end else begin
            stb_prev <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rand_ack) begin
            #1 output_z_ack = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   ok;
        bit   ack_seen;
        int   rises0;
        logic [7:0]  re;
        logic [22:0] rm;
        logic        rs;

        rst          = 1'b1;
        input_z      = '0;
        input_z_stb  = 1'b0;
        output_z_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_fill", 64'(fill_level), 64'd0);
        check("reset_stb", 64'(output_z_stb), 64'd0);
        check("reset_in_ack", 64'(input_z_ack), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // 1) single normal number, one stb pulse
        output_z_ack = 1'b1;
        rises0 = stb_rises;
        send_pair(32'h3FC0_0000);
        wait_drain("t1");
        check("t1_stb_pulses", 64'(stb_rises - rises0), 64'd1);

        // 2) + 3) inf, zero, denorm, NaN
        send_pair(32'h7F80_0000);
        send_pair(32'h8000_0000);
        send_pair(32'h0040_0000);
        send_pair(32'hFFC0_0000);
        wait_drain("t23");

        // 4) full FIFO stalls the 5th hi word
        output_z_ack = 1'b0;
        for (int i = 0; i < 4; i++) send_pair(32'h4000_0000 + 32'(i) * 32'h0010_0000);
        ack_seen = 1'b0;
        fork
            send_pair(32'h4100_0000);
            begin
                repeat (20) begin
                    @(negedge clk);
                    if (input_z_ack) ack_seen = 1'b1;
                end
                check("t4_fill_full", 64'(fill_level), 64'd4);
                check("t4_in_ack_stalled", 64'(ack_seen), 64'd0);
                @(posedge clk);
                #1 output_z_ack = 1'b1;
            end
        join
        wait_drain("t4");

        // 5) pop coincides with WRITE of the next entry
        output_z_ack = 1'b0;
        send_pair(32'h3F00_0000);
        repeat (2) @(posedge clk);
        #1;
        check("t5_fill_one", 64'(fill_level), 64'd1);
        send_word(16'h3E80, ok);
        send_word(16'h0001, ok);
        if (ok) begin
            sb_q.push_back(model(32'h3E80_0001));
            pushes++;
        end
        output_z_ack = 1'b1;
        @(posedge clk);
        #1 output_z_ack = 1'b0;
        check("t5_fill_unchanged", 64'(fill_level), 64'd1);
        check("t5_stb", 64'(output_z_stb), 64'd1);
        output_z_ack = 1'b1;
        wait_drain("t5");

        // 6) reset after a lone hi word discards it
        send_word(16'h1234, ok);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("t6_fill", 64'(fill_level), 64'd0);
        check("t6_stb", 64'(output_z_stb), 64'd0);
        send_pair(32'h3F80_0000);
        wait_drain("t6");

        // random results with random consumer back-pressure
        rand_ack = 1'b1;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       re = 8'h00;
                1:       re = 8'hFF;
                default: re = 8'($urandom_range(1, 254));
            endcase
            rm = ($urandom_range(0, 2) == 0) ? 23'd0 : 23'($urandom);
            rs = 1'($urandom_range(0, 1));
            send_pair({rs, re, rm});
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        rand_ack = 1'b0;
        @(posedge clk);
        #2 output_z_ack = 1'b1;
        wait_drain("rand");
        check("push_pop_count", 64'(pops), 64'(pushes));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
